// File: rtl/gray_pkg.sv
// Shared types and constants for the serial Gray-to-binary decoder.
// Optional step checking is enabled with GRAY_STEP_CHECK_EN (see gray_to_bin_serial).
package gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 9;

    // Legacy state encodings, kept bit-exact for existing tooling and waveforms
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DECODE = ST_DECODE,
        DONE   = ST_DONE
    } state_t;

    // Bit-index counter width for a word of w bits; never narrower than one bit
    function automatic int gray_idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Combinational test that two Gray words differ in exactly one bit position.
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_unit_step
);

    logic [WIDTH-1:0] w_diff;

    assign w_diff = i_a ^ i_b;

    // Exactly one set bit: non-zero and clearing the lowest set bit leaves nothing
    assign o_unit_step = (w_diff != '0) && ((w_diff & (w_diff - WIDTH'(1))) == '0);

endmodule

// File: rtl/gray_to_bin_serial.sv
// Serial MSB-first Gray-to-binary decoder with valid/ready on both sides.
// Define GRAY_STEP_CHECK_EN to flag accepted words that are not a unit Gray step.
module gray_to_bin_serial
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy,
    output logic             step_err
);

    localparam int                IDX_W   = gray_idx_w(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_bin;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_bin_up;
    logic [WIDTH-1:0] w_bin_next;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_idx == '0);

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == DECODE);
    assign out_valid = (r_state == DONE);
    assign bin_out   = r_bin;

    // bin_reg is cleared on accept, so the shifted-in zero above the MSB makes
    // bit WIDTH-1 come out as g[WIDTH-1] without a separate top-bit case.
    assign w_bin_up = {1'b0, r_bin[WIDTH-1:1]};

    always_comb begin
        w_bin_next = r_bin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_bin_next[i] = w_bin_up[i] ^ r_g[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_bin   <= '0;
            r_idx   <= IDX_MAX;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_g     <= gray_in;
                        r_bin   <= '0;
                        r_idx   <= IDX_MAX;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_bin <= w_bin_next;
                    if (w_last) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] r_prev;
    logic             r_prev_vld;
    logic             r_step_err;
    logic             w_unit_step;

    gray_step_checker #(
        .WIDTH(WIDTH)
    ) u_step_checker (
        .i_a        (gray_in),
        .i_b        (r_prev),
        .o_unit_step(w_unit_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_step_err <= 1'b0;
        end else begin
            r_step_err <= w_accept && r_prev_vld && !w_unit_step;
            if (w_accept) begin
                r_prev     <= gray_in;
                r_prev_vld <= 1'b1;
            end
        end
    end

    assign step_err = r_step_err;
`else
    assign step_err = 1'b0;
`endif

endmodule
